// File: rtl/seq_mult_ctrl_if.sv
// Operand/result handshake bundle for the sequential multiplier controller.
// Producer side drives operands and out_ready; the controller drives the rest.
// WIDTH must match the controller instance it connects to.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH:0]   out_product;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Shift-add controller for an unsigned WIDTH x WIDTH multiply reusing one accumulate adder.
// Latency: WIDTH RUN cycles from accept to out_valid (fewer with EARLY_EXIT for small in_b).
// Backpressure: result held in DONE until out_ready; no operands accepted until it drains.
module seq_mult_ctrl #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  seq_mult_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH:0]   acc_sum;
  logic [WIDTH-1:0]   mplier_nxt;
  logic               last_iter;

  // One shared adder plus the termination test for the current RUN step.
  always_comb begin
    acc_sum    = acc + {1'b0, mcand};
    mplier_nxt = mplier >> 1;
    last_iter  = (cnt == CNT_LAST) || (EARLY_EXIT && (mplier_nxt == '0));
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, bus.in_a};
            mplier <= bus.in_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0]) begin
            acc <= acc_sum;
          end
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.out_product = acc;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: one fixed-latency and one early-exit instance, 32-bit operands.
// Expected products come from plain a*b; expected latency from the position of b's top set bit.
// Inputs change 1 time unit after each rising edge; outputs are read in that same phase.
module tb_seq_mult_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  iv;
  logic [1:0]  ordy;
  logic [31:0] ia [2];
  logic [31:0] ib [2];
  logic [1:0]  ir;
  logic [1:0]  ov;
  logic [1:0]  bsy;
  logic [64:0] prod [2];

  int errors = 0;
  int checks = 0;

  seq_mult_ctrl_if #(.WIDTH(W)) if0 ();
  seq_mult_ctrl_if #(.WIDTH(W)) if1 ();

  seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if0.in_valid  = iv[0];
  assign if0.in_a      = ia[0];
  assign if0.in_b      = ib[0];
  assign if0.out_ready = ordy[0];
  assign if1.in_valid  = iv[1];
  assign if1.in_a      = ia[1];
  assign if1.in_b      = ib[1];
  assign if1.out_ready = ordy[1];

  assign ir      = {if1.in_ready, if0.in_ready};
  assign ov      = {if1.out_valid, if0.out_valid};
  assign bsy     = {if1.busy, if0.busy};
  assign prod[0] = if0.out_product;
  assign prod[1] = if1.out_product;

  // Reference: exact product, carry bit always zero.
  function automatic logic [64:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return {1'b0, full};
  endfunction

  // Reference: cycles from accept to out_valid.
  function automatic int ref_lat(input bit ee, input logic [31:0] b);
    if (!ee) return W;
    for (int i = W - 1; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
  endfunction

  // Present operands, wait for the accept edge, then count edges until out_valid.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [64:0] p, output bit to);
    int w;
    to = 1'b0;
    lat = 0;
    p = '0;
    ordy[s] = 1'b0;
    ia[s] = a;
    ib[s] = b;
    iv[s] = 1'b1;
    w = 0;
    while (!ir[s] && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!ir[s]) begin
      to = 1'b1;
      iv[s] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    iv[s] = 1'b0;
    ia[s] = $urandom;
    ib[s] = $urandom;
    while (!ov[s] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov[s]) to = 1'b1;
    p = prod[s];
  endtask

  task automatic drain(input int s);
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (ir[s] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", s, ir[s]); end
      checks++; if (ov[s] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", s, ov[s]); end
      checks++; if (prod[s] !== 65'd0) begin errors++; $display("FAIL reset_product[%0d] got=%h exp=0", s, prod[s]); end
      checks++; if (bsy[s] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", s, bsy[s]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [64:0] p; bit to;
    run_op(0, 32'd3, 32'd5, lat, p, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (lat != 32) begin errors++; $display("FAIL basic_latency got=%0d exp=32", lat); end
    checks++; if (p !== 65'h0_0000_0000_0000_000F) begin errors++; $display("FAIL basic_product got=%h exp=f", p); end
    checks++; if (bsy[0] !== 1'b1 || ir[0] !== 1'b0) begin errors++; $display("FAIL basic_done_flags busy=%b in_ready=%b exp busy=1 in_ready=0", bsy[0], ir[0]); end
    drain(0);
    checks++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_after_handshake in_ready=%b out_valid=%b busy=%b exp 1/0/0", ir[0], ov[0], bsy[0]);
    end
  endtask

  task automatic test_max();
    int lat; logic [64:0] p; bit to;
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, to);
    checks++; if (to) begin errors++; $display("FAIL max_timeout got=1 exp=0"); end
    checks++; if (p !== ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF)) begin errors++; $display("FAIL max_product got=%h exp=%h", p, ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF)); end
    checks++; if (p[64] !== 1'b0) begin errors++; $display("FAIL max_carry got=%b exp=0", p[64]); end
    drain(0);
  endtask

  task automatic test_backpressure();
    int lat; logic [64:0] p; bit to;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    run_op(0, a, b, lat, p, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
    iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ia[0] = $urandom; ib[0] = $urandom;
      @(posedge clk); #1;
      checks++; if (ov[0] !== 1'b1 || prod[0] !== ref_prod(a, b) || ir[0] !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b product=%h exp 1/0/%h", i, ov[0], ir[0], prod[0], ref_prod(a, b));
      end
    end
    iv[0] = 1'b0;
    drain(0);
    checks++; if (bsy[0] !== 1'b0 || ir[0] !== 1'b1) begin errors++; $display("FAIL bp_no_accept busy=%b in_ready=%b exp 0/1", bsy[0], ir[0]); end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [64:0] p; bit to;
    int w;
    ia[0] = $urandom | 32'h1; ib[0] = $urandom | 32'h1; iv[0] = 1'b1;
    w = 0;
    while (!ir[0] && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL midrun_busy_before got=%b exp=1", bsy[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0 || prod[0] !== 65'd0) begin
      errors++; $display("FAIL midrun_async in_ready=%b out_valid=%b busy=%b product=%h exp 1/0/0/0", ir[0], ov[0], bsy[0], prod[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 32'd7, 32'd6, lat, p, to);
    checks++; if (to || lat != 32) begin errors++; $display("FAIL midrun_relatency got=%0d timeout=%b exp=32", lat, to); end
    checks++; if (p !== 65'd42) begin errors++; $display("FAIL midrun_product got=%h exp=2a", p); end
    drain(0);
  endtask

  task automatic test_early_exit();
    logic [31:0] av [7];
    logic [31:0] bv [7];
    int lat; logic [64:0] p; bit to;
    av[0] = 32'h1234_5678; bv[0] = 32'h0000_0001;
    av[1] = 32'hDEAD_BEEF; bv[1] = 32'h0000_0000;
    av[2] = 32'h0000_0003; bv[2] = 32'h8000_0000;
    for (int i = 3; i < 7; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom >> $urandom_range(1, 31);
    end
    for (int i = 0; i < 7; i++) begin
      run_op(1, av[i], bv[i], lat, p, to);
      checks++; if (to || lat != ref_lat(1'b1, bv[i])) begin
        errors++; $display("FAIL ee_latency b=%h got=%0d exp=%0d", bv[i], lat, ref_lat(1'b1, bv[i]));
      end
      checks++; if (p !== ref_prod(av[i], bv[i])) begin
        errors++; $display("FAIL ee_product a=%h b=%h got=%h exp=%h", av[i], bv[i], p, ref_prod(av[i], bv[i]));
      end
      drain(1);
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] q[$];
    int acc_cyc[$];
    int cyc, got;
    logic [64:0] e;
    cyc = 0; got = 0;
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    ia[0] = $urandom; ib[0] = $urandom;
    while (got < 5 && cyc < 400) begin
      if (ov[0]) begin
        e = q.pop_front();
        got++;
        checks++; if (prod[0] !== e) begin errors++; $display("FAIL b2b_product idx=%0d got=%h exp=%h", got, prod[0], e); end
      end
      if (ir[0] && iv[0]) begin
        q.push_back(ref_prod(ia[0], ib[0]));
        acc_cyc.push_back(cyc);
        @(posedge clk); #1;
        ia[0] = $urandom; ib[0] = $urandom;
        if (acc_cyc.size() >= 5) iv[0] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    checks++; if (got != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", got); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
        errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
      end
    end
  endtask

  task automatic test_random(input int s, input int n);
    logic [64:0] q[$];
    int sent, recv, cyc, limit;
    bit acc_now;
    logic [64:0] e;
    sent = 0; recv = 0; cyc = 0;
    limit = n * 90;
    iv[s] = 1'b0;
    while (recv < n && cyc < limit) begin
      if (!iv[s] && sent < n && $urandom_range(0, 3) != 0) begin
        iv[s] = 1'b1;
        ia[s] = $urandom;
        ib[s] = (s == 1) ? ($urandom >> $urandom_range(0, 32)) : $urandom;
      end
      ordy[s] = ($urandom_range(0, 2) != 0);
      acc_now = iv[s] && ir[s];
      if (acc_now) begin
        q.push_back(ref_prod(ia[s], ib[s]));
        sent++;
      end
      if (ov[s] && ordy[s]) begin
        recv++;
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_dup dut=%0d result with no pending operands", s);
        end else begin
          e = q.pop_front();
          checks++; if (prod[s] !== e) begin errors++; $display("FAIL rand_product dut=%0d idx=%0d got=%h exp=%h", s, recv, prod[s], e); end
        end
      end
      @(posedge clk); #1;
      if (acc_now) iv[s] = 1'b0;
      cyc++;
    end
    iv[s] = 1'b0;
    ordy[s] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (sent != n || recv != n) begin errors++; $display("FAIL rand_counts dut=%0d sent=%0d recv=%0d exp=%0d", s, sent, recv, n); end
    checks++; if (q.size() != 0 || ov[s] !== 1'b0) begin errors++; $display("FAIL rand_leftover dut=%0d pending=%0d out_valid=%b exp 0/0", s, q.size(), ov[s]); end
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    for (int s = 0; s < 2; s++) begin ia[s] = '0; ib[s] = '0; end
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_reset_midrun();
    test_early_exit();
    test_back_to_back();
    test_random(0, 300);
    test_random(1, 1500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
